morty_hazard_ctrl: RTL

- Pipeline hazard and flush controller for the 5-stage core.
- Sole driver of the stall_*/clear_* inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and of the PC-source select.
- Resolves load-use hazards, multi-cycle MDU operations, data-memory wait states, taken branches and traps.
- Holds a small state machine and counters so that multi-cycle events produce correctly timed stall/bubble sequences.

---
 rtl/morty_hazard_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/morty_hazard_ctrl.sv
// Pipeline hazard and flush controller for the 5-stage core: drives all pipeline-register
// stall/clear controls and the PC-source select from a small RUN/MDU_WAIT/TRAP_FLUSH FSM.
module morty_hazard_ctrl #(
   parameter int unsigned TRAP_FLUSH_CYCLES = 1,
   parameter int unsigned MDU_TIMEOUT       = 64
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [4:0] i_id_rs1,
   input  logic [4:0] i_id_rs2,
   input  logic       i_id_uses_rs1,
   input  logic       i_id_uses_rs2,
   input  logic [4:0] i_ex_rd,
   input  logic       i_ex_regwrite,
   input  logic       i_ex_is_load,
   input  logic       i_ex_mdu_start,
   input  logic       i_ex_mdu_done,
   input  logic       i_ex_branch_taken,
   input  logic       i_mem_wait,
   input  logic       i_trap_req,
   output logic       o_stall_pc,
   output logic       o_stall_ifid,
   output logic       o_clear_ifid,
   output logic       o_stall_idex,
   output logic       o_clear_idex,
   output logic       o_stall_exmem,
   output logic       o_clear_exmem,
   output logic       o_clear_memwb,
   output logic [1:0] o_pc_sel,
   output logic       o_mdu_timeout
);

   typedef enum logic [1:0] {StRun, StMduWait, StTrapFlush} state_e;

   localparam logic [2:0] FlushInit = 3'(TRAP_FLUSH_CYCLES);
   localparam logic [7:0] WdLast    = 8'(MDU_TIMEOUT - 1);

   localparam logic [1:0] PcSeq    = 2'd0;
   localparam logic [1:0] PcBranch = 2'd1;
   localparam logic [1:0] PcTrap   = 2'd2;

   state_e     r_state,     w_state_nxt;
   logic [2:0] r_flush_cnt, w_flush_cnt_nxt;
   logic [7:0] r_wd,        w_wd_nxt;
   logic       r_trap_pend, w_trap_pend_nxt;

   logic w_trap_take;
   logic w_load_use;

   assign w_trap_take = (i_trap_req | r_trap_pend) & ~i_mem_wait;
   assign w_load_use  = i_ex_is_load & i_ex_regwrite & (i_ex_rd != 5'd0) &
                        ((i_id_uses_rs1 & (i_id_rs1 == i_ex_rd)) |
                         (i_id_uses_rs2 & (i_id_rs2 == i_ex_rd)));

   always_comb begin
      o_stall_pc      = 1'b0;
      o_stall_ifid    = 1'b0;
      o_clear_ifid    = 1'b0;
      o_stall_idex    = 1'b0;
      o_clear_idex    = 1'b0;
      o_stall_exmem   = 1'b0;
      o_clear_exmem   = 1'b0;
      o_clear_memwb   = 1'b0;
      o_pc_sel        = PcSeq;
      o_mdu_timeout   = 1'b0;
      w_state_nxt     = r_state;
      w_flush_cnt_nxt = r_flush_cnt;
      w_wd_nxt        = r_wd;
      w_trap_pend_nxt = r_trap_pend;

      if (!i_rst) begin
         // Reset is asynchronous, so the bubbles must appear without waiting for a clock edge.
         o_clear_ifid  = 1'b1;
         o_clear_idex  = 1'b1;
         o_clear_exmem = 1'b1;
         o_clear_memwb = 1'b1;
      end else if (w_trap_take) begin
         o_pc_sel        = PcTrap;
         o_clear_ifid    = 1'b1;
         o_clear_idex    = 1'b1;
         o_clear_exmem   = 1'b1;
         w_state_nxt     = StTrapFlush;
         w_flush_cnt_nxt = FlushInit;
         w_wd_nxt        = 8'd0;
         w_trap_pend_nxt = 1'b0;
      end else if (i_mem_wait) begin
         // Whole pipe holds; MEM/WB gets a bubble since MEM produced nothing this cycle.
         if (i_trap_req) w_trap_pend_nxt = 1'b1;
         o_stall_pc    = 1'b1;
         o_stall_ifid  = 1'b1;
         o_stall_idex  = 1'b1;
         o_stall_exmem = 1'b1;
         o_clear_memwb = 1'b1;
      end else begin
         unique case (r_state)
            StTrapFlush: begin
               o_clear_ifid = 1'b1;
               o_clear_idex = 1'b1;
               if (r_flush_cnt <= 3'd1) begin
                  w_flush_cnt_nxt = 3'd0;
                  w_state_nxt     = StRun;
               end else begin
                  w_flush_cnt_nxt = r_flush_cnt - 3'd1;
               end
            end
            StMduWait: begin
               if (i_ex_mdu_done) begin
                  w_state_nxt = StRun;
               end else if (r_wd == WdLast) begin
                  o_mdu_timeout = 1'b1;
                  w_state_nxt   = StRun;
               end else begin
                  o_stall_pc    = 1'b1;
                  o_stall_ifid  = 1'b1;
                  o_stall_idex  = 1'b1;
                  o_clear_exmem = 1'b1;
                  w_wd_nxt      = r_wd + 8'd1;
               end
            end
            StRun: begin
               if (i_ex_branch_taken) begin
                  o_pc_sel     = PcBranch;
                  o_clear_ifid = 1'b1;
                  o_clear_idex = 1'b1;
               end else if (i_ex_mdu_start) begin
                  o_stall_pc    = 1'b1;
                  o_stall_ifid  = 1'b1;
                  o_stall_idex  = 1'b1;
                  o_clear_exmem = 1'b1;
                  w_state_nxt   = StMduWait;
                  w_wd_nxt      = 8'd0;
               end else if (w_load_use) begin
                  o_stall_pc   = 1'b1;
                  o_stall_ifid = 1'b1;
                  o_clear_idex = 1'b1;
               end
            end
            default: w_state_nxt = StRun;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state     <= StRun;
         r_flush_cnt <= 3'd0;
         r_wd        <= 8'd0;
         r_trap_pend <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_flush_cnt <= w_flush_cnt_nxt;
         r_wd        <= w_wd_nxt;
         r_trap_pend <= w_trap_pend_nxt;
      end
   end

endmodule
